// File: rtl/gate_test_sequencer_if.sv
`default_nettype none
// ============================================================================
// gate_test_sequencer_if : control, status and stimulus bus of the sequencer
// Revision 1.0
// ============================================================================
interface gate_test_sequencer_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic            fail_valid;
  logic [N_IN-1:0] fail_vec;

  // master = sequencer side, slave = gate + run controller side
  modport master (
    input  start, dut_out,
    output dut_in, busy, done, pass, err_cnt, fail_valid, fail_vec
  );
  modport slave (
    output start, dut_out,
    input  dut_in, busy, done, pass, err_cnt, fail_valid, fail_vec
  );
endinterface
`default_nettype wire

// File: rtl/gate_test_sequencer.sv
`default_nettype none
// ============================================================================
// gate_test_sequencer : walks all input vectors of a small gate, checks its
//                       output against a truth table, reports the result
// Revision 1.0
// ============================================================================
module gate_test_sequencer #(
  parameter int                     N_IN   = 2,
  parameter int                     SETTLE = 4,
  parameter logic [(1<<N_IN)-1:0]   EXP_TT = 4'b0110
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gate_test_sequencer_if.master bus
);

  localparam int            CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [N_IN:0] ERR_MAX = {1'b1, {N_IN{1'b0}}};
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_cnt_q, err_cnt_d;
  logic            fail_valid_q, fail_valid_d;
  logic [N_IN-1:0] fail_vec_q, fail_vec_d;
  logic            mismatch;

  // dut_in_q doubles as the vector index
  assign mismatch = (bus.dut_out != EXP_TT[dut_in_q]);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dut_in_d     = dut_in_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d      = ST_APPLY;
          dut_in_d     = '0;
          err_cnt_d    = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
        end
      end
      ST_APPLY: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = dut_in_q;
          end
        end
        if (dut_in_q == VEC_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          // include the verdict of this final sample
          pass_d  = (err_cnt_q == '0) && !mismatch;
        end else begin
          dut_in_d = dut_in_q + 1'b1;
          state_d  = ST_APPLY;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dut_in_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dut_in_q     <= dut_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign bus.dut_in     = dut_in_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_vec   = fail_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_test_sequencer.sv
`default_nettype none
// ============================================================================
// tb_gate_test_sequencer : directed bench for gate_test_sequencer
// Revision 1.0
// ============================================================================
module tb_gate_test_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [1:0] mode_a;   // 0 = XOR, 1 = stuck-at-0, 2 = XNOR
  logic       glitch_b;

  gate_test_sequencer_if #(.N_IN(2)) bus_a ();
  gate_test_sequencer_if #(.N_IN(3)) bus_b ();

  gate_test_sequencer #(.N_IN(2), .SETTLE(4), .EXP_TT(4'b0110)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.master)
  );

  gate_test_sequencer #(.N_IN(3), .SETTLE(1), .EXP_TT(8'h96)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.master)
  );

  assign bus_a.dut_out = (mode_a == 2'd0) ? (^bus_a.dut_in) :
                         (mode_a == 2'd1) ? 1'b0 : ~(^bus_a.dut_in);
  assign bus_b.dut_out = (^bus_b.dut_in) ^ glitch_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_zero_a(input string tag);
    check_val({tag, "_dut_in"}, int'(bus_a.dut_in), 0);
    check_val({tag, "_busy"},   int'(bus_a.busy), 0);
    check_val({tag, "_done"},   int'(bus_a.done), 0);
    check_val({tag, "_pass"},   int'(bus_a.pass), 0);
    check_val({tag, "_err"},    int'(bus_a.err_cnt), 0);
    check_val({tag, "_fv"},     int'(bus_a.fail_valid), 0);
    check_val({tag, "_fvec"},   int'(bus_a.fail_vec), 0);
  endtask

  // One full run on DUT A; start accepted at edge 0, checks after edges 0..25
  task automatic run_a(input string tag, input logic [1:0] mode, input bit poke,
                       input int exp_err, input int exp_fv, input int exp_fvec,
                       input int exp_pass);
    mode_a = mode;
    @(negedge clk);
    bus_a.start = 1'b1;
    for (int n = 0; n <= 25; n++) begin
      @(negedge clk);
      bus_a.start = poke && (n == 4 || n == 19);
      check_val($sformatf("%s_in%0d", tag, n), int'(bus_a.dut_in), (n < 24) ? n / 6 : 3);
      check_val($sformatf("%s_busy%0d", tag, n), int'(bus_a.busy), (n < 24) ? 1 : 0);
      check_val($sformatf("%s_done%0d", tag, n), int'(bus_a.done), (n == 24) ? 1 : 0);
      if (n == 0) check_val({tag, "_errclr"}, int'(bus_a.err_cnt), 0);
    end
    check_val({tag, "_err"},  int'(bus_a.err_cnt), exp_err);
    check_val({tag, "_fv"},   int'(bus_a.fail_valid), exp_fv);
    if (exp_fv != 0) check_val({tag, "_fvec"}, int'(bus_a.fail_vec), exp_fvec);
    check_val({tag, "_pass"}, int'(bus_a.pass), exp_pass);
  endtask

  initial begin
    int k;
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    mode_a      = 2'd0;
    glitch_b    = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_a("rst");
    check_val("rst_b_busy", int'(bus_b.busy), 0);
    check_val("rst_b_in", int'(bus_b.dut_in), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_a("xor",   2'd0, 1'b0, 0, 0, 0, 1);
    run_a("stuck", 2'd1, 1'b0, 2, 1, 1, 0);
    run_a("xnor",  2'd2, 1'b0, 4, 1, 0, 0);
    run_a("rerun", 2'd0, 1'b0, 0, 0, 0, 1);
    run_a("poke",  2'd0, 1'b1, 0, 0, 0, 1);

    // start held through DONE: second run accepted at edge 26
    mode_a = 2'd0;
    @(negedge clk);
    bus_a.start = 1'b1;
    for (int n = 0; n <= 27; n++) begin
      @(negedge clk);
      if (n <= 24) begin
        check_val($sformatf("hold_busy%0d", n), int'(bus_a.busy), (n < 24) ? 1 : 0);
        check_val($sformatf("hold_done%0d", n), int'(bus_a.done), (n == 24) ? 1 : 0);
      end
      if (n == 25) begin
        check_val("hold_busy25", int'(bus_a.busy), 0);
        check_val("hold_done25", int'(bus_a.done), 0);
        check_val("hold_pass25", int'(bus_a.pass), 1);
      end
      if (n == 26) begin
        check_val("hold_busy26", int'(bus_a.busy), 1);
        check_val("hold_in26",   int'(bus_a.dut_in), 0);
        check_val("hold_pass26", int'(bus_a.pass), 0);
        bus_a.start = 1'b0;
      end
      if (n == 27) check_val("hold_busy27", int'(bus_a.busy), 1);
    end
    k = 0;
    while (k < 40 && !bus_a.done) begin
      @(negedge clk);
      k++;
    end
    check_val("hold_done2_lat", k, 23);
    check_val("hold_pass2", int'(bus_a.pass), 1);
    @(negedge clk);

    // asynchronous reset mid-run with a failing gate
    mode_a = 2'd1;
    @(negedge clk);
    bus_a.start = 1'b1;
    for (int n = 0; n <= 10; n++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
    end
    check_val("prerst_in", int'(bus_a.dut_in), 1);
    rst_n = 1'b0;
    #1;
    check_zero_a("midrst");
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 5) rst_n = 1'b1;
      check_val($sformatf("midrst_done%0d", n), int'(bus_a.done), 0);
      check_val($sformatf("midrst_busy%0d", n), int'(bus_a.busy), 0);
    end
    run_a("postrst", 2'd0, 1'b0, 0, 0, 0, 1);

    // DUT B: wrong output during WAIT only, correct at SAMPLE
    @(negedge clk);
    bus_b.start = 1'b1;
    for (int n = 0; n <= 25; n++) begin
      @(negedge clk);
      bus_b.start = 1'b0;
      glitch_b = (n < 24) && (n % 3 == 1);
      check_val($sformatf("glitch_in%0d", n), int'(bus_b.dut_in), (n < 24) ? n / 3 : 7);
      check_val($sformatf("glitch_busy%0d", n), int'(bus_b.busy), (n < 24) ? 1 : 0);
      check_val($sformatf("glitch_done%0d", n), int'(bus_b.done), (n == 24) ? 1 : 0);
    end
    check_val("glitch_pass", int'(bus_b.pass), 1);
    check_val("glitch_err",  int'(bus_b.err_cnt), 0);
    check_val("glitch_fv",   int'(bus_b.fail_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
